// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, reset PC, bubble encoding
// and the IF/ID pipeline register payload.
package rv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

   // Payload presented to decode when a bubble is injected.
   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.instr    = NOP_INSTR;
      b.pc       = '0;
      b.pc_plus4 = '0;
      b.valid    = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and clear load a bubble, enable low holds.
// Priority is rst > clr > hold > capture.
module if_id_reg
   import rv_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   clr,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t state_q;
   if_id_t state_d;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = if_id_bubble();
      end else if (en) begin
         state_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= if_id_bubble();
      end else begin
         state_q <= state_d;
      end
   end

   assign q = state_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// All outputs come straight from flops; IMEM is read combinationally at PCF.
module fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic [31:0]     InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   import rv_pkg::*;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_plus4_f;
   logic [XLEN-1:0] pc_target_aligned;

   if_id_t if_id_d;
   if_id_t if_id_q;

   assign pc_plus4_f        = pc_q + XLEN'(4);
   assign pc_target_aligned = {PCTargetE[XLEN-1:2], 2'b00};

   // A redirect must win over a concurrent stall or the branch would be lost.
   always_comb begin
      pc_d = pc_plus4_f;
      if (PCSrcE) begin
         pc_d = pc_target_aligned;
      end else if (StallF) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      if_id_d.instr    = InstrF;
      if_id_d.pc       = pc_q;
      if_id_d.pc_plus4 = pc_plus4_f;
      if_id_d.valid    = 1'b1;
   end

   if_id_reg u_if_id_reg (
      .clk (clk),
      .rst (rst),
      .en  (~StallD),
      .clr (FlushD),
      .d   (if_id_d),
      .q   (if_id_q)
   );

   assign PCF      = pc_q;
   assign InstrD   = if_id_q.instr;
   assign PCD      = if_id_q.pc;
   assign PCPlus4D = if_id_q.pc_plus4;
   assign ValidD   = if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. It holds the program counter, computes PC+4, selects the next PC from the sequential or redirect path, and presents the fetch address to an external combinational instruction memory. It also owns the IF/ID pipeline register that drives InstrD, PCD and PCPlus4D into decode, with stall and flush control from the hazard unit.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected on reset/flush

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
StallF  in  1  hold PC (hazard unit)
StallD  in  1  hold IF/ID register (hazard unit)
FlushD  in  1  replace IF/ID contents with bubble
PCSrcE  in  1  taken branch/jump resolved in execute
PCTargetE  in  XLEN  redirect target from execute
InstrF  in  32  instruction word from IMEM at PCF (combinational read)
PCF  out  XLEN  current fetch address to IMEM
InstrD  out  32  instruction to decode
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
ValidD  out  1  1 = InstrD is a real fetched instruction, 0 = bubble

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on rising clk edge.
- Reset values: PCF=RESET_PC; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0.
- PCPlus4F = PCF + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000, no flag).
- PC next-state priority per edge: rst > PCSrcE (PCF <= {PCTargetE[XLEN-1:2],2'b00}) > StallF (hold) > PCF <= PCPlus4F.
- PCSrcE overrides StallF: a redirect is never lost to a concurrent load-use stall.
- PCTargetE[1:0] ignored (forced 0); no misalignment exception in this block.
- IF/ID priority per edge: rst > FlushD (InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0) > StallD (hold all four) > capture (InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1).
- Latency: instruction at PCF appears on InstrD one cycle later; a redirect asserted in cycle n gives PCF=target in cycle n+1.
- Outputs are purely registered; PCF is driven directly from the PC register. No combinational path from any input to any output.
- StallF/StallD are independent; normal use has both asserted together. StallD without StallF is legal: the fetched word is dropped and PC advances.
- Reset mid-stall or mid-flush: rst wins; state after the edge equals the reset values.

Decomposition:
- Shared package rv_pkg: XLEN, RESET_PC, NOP_INSTR localparams; typedef if_id_t struct {instr, pc, pc_plus4, valid}.
- One sub-module: if_id_reg (enable + synchronous clear + reset, carries if_id_t). The PC register and next-PC mux stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with IMEM[k]=k*4+0x13 -> PCF=0, InstrD=0x13, ValidD=0; after 1 edge InstrD=IMEM[0], PCD=0, PCPlus4D=4, ValidD=1; PCF then steps 4, 8, 12.
- Stall: StallF=StallD=1 for 2 cycles at PCF=0x10 -> PCF stays 0x10, InstrD/PCD stay at the 0x0C values; on release PCF=0x14 next edge.
- Redirect+flush: PCSrcE=1, PCTargetE=0x100, FlushD=1 at PCF=0x20 -> next edge PCF=0x100, InstrD=0x13, ValidD=0; following edge PCD=0x100.
- Redirect vs stall: PCSrcE=1, StallF=1, StallD=1, FlushD=1, PCTargetE=0x203 -> PCF=0x200, InstrD=NOP, ValidD=0.
- Wrap: force PC to 0xFFFF_FFFC via redirect -> next PCF=0x0000_0000, PCPlus4D=0x0000_0000 for that instruction.
- Reset during stall: StallF=StallD=1 and rst=1 at PCF=0x40 -> next edge PCF=RESET_PC, ValidD=0.
